ntt_frame_serializer: RTL and testbench
=======================================

# ntt_frame_serializer

Sits directly downstream of the pipelined radix-2 NTT/iNTT block. It captures each parallel, bit-reversed N-word result frame into a two-bank ping-pong buffer and restores natural coefficient order. For iNTT frames it applies the final N⁻¹ mod Q scaling. It streams coefficients out one per cycle over a valid/ready handshake, and exposes a full flag so the producer can throttle.

## Interface
- W, 32, coefficient width
- N, 8, frame length (power of 2, ≥ 2)
- Q, 241, modulus (Q < 2^W)
- N_INV, 211, N⁻¹ mod Q (8·211 ≡ 1 mod 241)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- frame_valid_in  in  1  frame_in/frame_mode_in valid this cycle (no backpressure)
- frame_mode_in  in  1  0 = forward NTT result, 1 = iNTT result
- frame_in  in  W×[0:N-1]  frame in bit-reversed order
- buf_full  out  1  both banks occupied; a frame presented now is dropped
- coef_out  out  W  coefficient, natural order
- coef_idx_out  out  log2(N)  natural index of coef_out
- coef_mode_out  out  1  mode of the frame coef_out belongs to
- coef_last_out  out  1  coef_idx_out == N-1
- coef_valid_out  out  1  output beat valid
- coef_ready_in  in  1  consumer accepts beat
- overflow_out  out  1  one-cycle pulse per dropped frame
- drop_count  out  8  saturating count of dropped frames

## Operation
- **Storage:** banks B0/B1, each N×W data plus a mode bit. Occupancy is a count of 0..2, a write pointer, and a read pointer with read index ri. The data arrays are not reset.
- **Capture:** when frame_valid_in=1 and a bank is free, write bank[wr][i] ← frame_in[bitrev(i)] and latch the mode. Then mark the bank occupied and toggle wr.
- **A bank is free when** count<2, or count==2 and the read side releases a bank on the same edge.
  - Write and release of the same bank on one edge is legal: the read samples the old data.
- **Drop:** if no bank is free, discard the frame. Pulse overflow_out for one cycle and increment drop_count, saturating at 255.
- **Output register load condition:** (!coef_valid_out || coef_ready_in) && count>0, counting only banks not yet released.
- **On load:**
  - coef_out ← mode ? (bank[rd][ri]·N_INV) mod Q : bank[rd][ri]. The product is 2W wide, reduced mod Q, and the result is < Q.
  - idx, mode and last are loaded alongside coef_out.
  - ri increments. When ri was N-1, the bank is released: count decrements, rd toggles and ri returns to 0.
- **Drain:** if coef_ready_in=1 with no load, coef_valid_out clears.
- **Handshake rules:**
  - While coef_valid_out=1 && coef_ready_in=0, all coef_* outputs hold stable.
  - A beat transfers on valid && ready.
- **Read FSM:** IDLE (count==0, output empty) → STREAM (loading) → IDLE after the last beat drains with count==0. Back-to-back banks stream with no bubble.
- **Reset (any time, including mid-frame):** count=0, wr=rd=0, ri=0, coef_out=0, coef_idx_out=0, coef_mode_out=0, coef_last_out=0, coef_valid_out=0, buf_full=0, overflow_out=0, drop_count=0. Partial frames are lost.

## Timing
- A frame is sampled at edge E0, and buf_full reflects the new count after E0.
- Coefficient 0 appears with coef_valid_out=1 after edge E1, provided the output register was empty or accepted at E1.
- Throughput is 1 coefficient per cycle. A frame drains in N accepted beats; a bank frees on the edge its last element loads.
- buf_full = (count==2), registered.
- overflow_out is asserted in the cycle after the dropping edge.
- The producer must not present frames faster than one per N cycles on average. buf_full is the throttle.

## Structure
- Package ntt_pkg holds:
  - the bitrev function parameterised by log2(N);
  - the default Q, N_INV and W constants;
  - the bank-index typedef.
- Sub-module ntt_modmul_const: combinational (a·k) mod Q, W-bit in/out, 2W intermediate. It is instantiated once on the read path.

## Test plan
- **Forward order restore:** NTT frame (N=8, Q=241) with frame_in={0,40,20,60,10,50,30,70} and ready=1 → coef_out 0,10,20,…,70, idx 0..7, last only on idx 7, mode=0, first valid one cycle after capture.
- **iNTT scaling:** the same frame with mode=1 → coef_out 0,182,123,… (i.e. 10i·211 mod 241), mode=1.
- **Backpressure:** ready=0 for 3 cycles while idx=2 is presented → coef_out/idx hold at the idx=2 value, then streaming resumes with no skipped or duplicated index.
- **Overflow:** three frames on consecutive cycles with ready=0:
  - buf_full=1 after the second frame;
  - the third frame is dropped, with a single overflow_out pulse and drop_count=1;
  - raising ready streams frames 1 and 2 only, back-to-back with no bubble.
- **Simultaneous release/write:** count=2 and a frame arrives on the edge the last element of the oldest bank loads → no drop; the new frame streams after the intervening frame.
- **Reset mid-stream:** assert reset at idx=4 → all outputs 0 immediately. A new frame after release streams from idx 0 with the correct data.

Source files
------------

// File: rtl/ntt_frame_serializer_pkg.sv
// ntt_pkg: shared constants, bank/state types and the bit-reversal helper
// used by the NTT frame serializer and its modular-multiply sub-block.
package ntt_pkg;

    localparam int W_DEF     = 32;
    localparam int N_DEF     = 8;
    localparam int Q_DEF     = 241;
    localparam int N_INV_DEF = 211;

    typedef logic bank_t;

    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

    // Reverses the low lg bits of i.
    function automatic int unsigned bitrev(input int unsigned i, input int unsigned lg);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < lg; b++) r = (r << 1) | ((i >> b) & 32'd1);
        return r;
    endfunction

endpackage

// File: rtl/ntt_frame_serializer_modmul_const.sv
// ntt_modmul_const: combinational (a_i * K) mod Q with a 2W-bit product.
//   a_i  in  W  operand
//   p_o  out W  reduced product, always < Q
module ntt_modmul_const
    import ntt_pkg::*;
#(
    parameter int           W = W_DEF,
    parameter logic [W-1:0] Q = W'(Q_DEF),
    parameter logic [W-1:0] K = W'(N_INV_DEF)
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] p_o
);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, K};
    assign p_o  = W'(prod % {{W{1'b0}}, Q});

endmodule

// File: rtl/ntt_frame_serializer.sv
// ntt_frame_serializer: captures bit-reversed NTT/iNTT result frames into a
// two-bank ping-pong buffer and streams them out in natural order, scaling
// iNTT frames by N^-1 mod Q.
//   clk, reset              clock, asynchronous active-high reset
//   frame_valid_in/mode/in  parallel frame input (bit-reversed), no backpressure
//   buf_full                both banks occupied (registered)
//   coef_*_out / ready_in   one coefficient per beat, valid/ready handshake
//   overflow_out            one-cycle pulse per dropped frame
//   drop_count              saturating dropped-frame count
module ntt_frame_serializer
    import ntt_pkg::*;
#(
    parameter int           W     = W_DEF,
    parameter int           N     = N_DEF,
    parameter logic [W-1:0] Q     = W'(Q_DEF),
    parameter logic [W-1:0] N_INV = W'(N_INV_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_valid_in,
    input  logic                    frame_mode_in,
    input  logic [0:N-1][W-1:0]     frame_in,
    output logic                    buf_full,
    output logic [W-1:0]            coef_out,
    output logic [$clog2(N)-1:0]    coef_idx_out,
    output logic                    coef_mode_out,
    output logic                    coef_last_out,
    output logic                    coef_valid_out,
    input  logic                    coef_ready_in,
    output logic                    overflow_out,
    output logic [7:0]              drop_count
);

    localparam int LG = $clog2(N);

    logic [0:N-1][W-1:0] frame_nat;
    logic [0:N-1][W-1:0] mem_q [2];
    logic                mode_q [2];
    logic [1:0]          count_q, count_d;
    bank_t               wr_q, rd_q;
    logic [LG-1:0]       ri_q;
    rd_state_e           state_q;
    logic [W-1:0]        rd_word, scaled, coef_d;
    logic                load, rel, cap, drop;
    logic [W-1:0]        coef_q;
    logic [LG-1:0]       idx_q;
    logic                cmode_q, last_q, valid_q, full_q, ovf_q;
    logic [7:0]          drops_q;

    for (genvar j = 0; j < N; j++) begin : g_br
        assign frame_nat[j] = frame_in[bitrev(j, LG)];
    end

    ntt_modmul_const #(.W(W), .Q(Q), .K(N_INV)) u_modmul (
        .a_i(rd_word),
        .p_o(scaled)
    );

    // A bank released on this edge is free for a frame arriving on the same
    // edge; the read of its last word still sees the old contents.
    always_comb begin
        load    = (!valid_q || coef_ready_in) && (count_q != 2'd0);
        rel     = load && (ri_q == LG'(N - 1));
        cap     = frame_valid_in && ((count_q != 2'd2) || rel);
        drop    = frame_valid_in && !cap;
        count_d = count_q + {1'b0, cap} - {1'b0, rel};
        rd_word = mem_q[rd_q][ri_q];
        coef_d  = mode_q[rd_q] ? scaled : rd_word;
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem_q[wr_q]  <= frame_nat;
            mode_q[wr_q] <= frame_mode_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ri_q    <= '0;
            coef_q  <= '0;
            idx_q   <= '0;
            cmode_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drops_q <= 8'd0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == 2'd2);
            wr_q    <= wr_q ^ cap;
            rd_q    <= rd_q ^ rel;
            ovf_q   <= drop;
            if (drop && drops_q != 8'hFF) drops_q <= drops_q + 8'd1;
            if (load) begin
                ri_q    <= ri_q + 1'b1;
                coef_q  <= coef_d;
                idx_q   <= ri_q;
                cmode_q <= mode_q[rd_q];
                last_q  <= (ri_q == LG'(N - 1));
                valid_q <= 1'b1;
            end else if (coef_ready_in) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                RD_IDLE:   if (load) state_q <= RD_STREAM;
                RD_STREAM: if (!load && coef_ready_in && count_q == 2'd0) state_q <= RD_IDLE;
            endcase
        end
    end

    assign buf_full       = full_q;
    assign coef_out       = coef_q;
    assign coef_idx_out   = idx_q;
    assign coef_mode_out  = cmode_q;
    assign coef_last_out  = last_q;
    assign coef_valid_out = valid_q;
    assign overflow_out   = ovf_q;
    assign drop_count     = drops_q;

endmodule

// File: tb/tb_ntt_frame_serializer.sv
// tb_ntt_frame_serializer: scoreboard bench for the NTT frame serializer.
module tb_ntt_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, frame_valid_in, frame_mode_in, coef_ready_in;
    logic [0:7][31:0] frame_in;
    logic             buf_full, coef_mode_out, coef_last_out, coef_valid_out, overflow_out;
    logic [31:0]      coef_out;
    logic [2:0]       coef_idx_out;
    logic [7:0]       drop_count;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  idx;
        logic        m;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    beat_t       hold;
    logic        hold_v = 1'b0;
    int          tests = 0, fails = 0, exp_drops = 0;
    logic [31:0] nat [8];

    ntt_frame_serializer dut (
        .clk(clk), .reset(reset),
        .frame_valid_in(frame_valid_in), .frame_mode_in(frame_mode_in), .frame_in(frame_in),
        .buf_full(buf_full), .coef_out(coef_out), .coef_idx_out(coef_idx_out),
        .coef_mode_out(coef_mode_out), .coef_last_out(coef_last_out),
        .coef_valid_out(coef_valid_out), .coef_ready_in(coef_ready_in),
        .overflow_out(overflow_out), .drop_count(drop_count)
    );

    function automatic logic [2:0] br(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    function automatic logic [31:0] exp_coef(input logic [31:0] x, input logic m);
        return m ? 32'((64'(x) * 64'd211) % 64'd241) : x;
    endfunction

    // One clock: scoreboard/hold checks at the negedge, then step past posedge.
    task automatic tick();
        beat_t got, e;
        @(negedge clk);
        got = {coef_out, coef_idx_out, coef_mode_out, coef_last_out};
        if (hold_v && !reset) begin
            tests++;
            if (!coef_valid_out || got !== hold) begin
                fails++;
                $display("FAIL hold: got valid=%0b d=%0d idx=%0d, required valid=1 d=%0d idx=%0d",
                         coef_valid_out, got.d, got.idx, hold.d, hold.idx);
            end
        end
        hold_v = coef_valid_out && !coef_ready_in;
        hold = got;
        if (coef_valid_out && coef_ready_in) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL beat: got unexpected d=%0d idx=%0d, required no beat", got.d, got.idx);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL beat: got d=%0d idx=%0d m=%0b last=%0b, required d=%0d idx=%0d m=%0b last=%0b",
                             got.d, got.idx, got.m, got.last, e.d, e.idx, e.m, e.last);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) nat[i] = $urandom;
    endtask

    task automatic present(input logic m, input bit keep);
        for (int i = 0; i < 8; i++) frame_in[br(3'(i))] = nat[i];
        frame_mode_in = m;
        frame_valid_in = 1'b1;
        if (keep) for (int i = 0; i < 8; i++) sb.push_back({exp_coef(nat[i], m), 3'(i), m, (i == 7)});
        tick();
        frame_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        coef_ready_in = 1'b1;
        while ((sb.size() != 0 || coef_valid_out) && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (sb.size() != 0 || coef_valid_out) begin
            fails++;
            $display("FAIL %s drain: got %0d beats left valid=%0b, required 0 left valid=0", name, sb.size(), coef_valid_out);
        end
    endtask

    task automatic wait_idx(input string name, input logic [2:0] k);
        int n = 0;
        while (!(coef_valid_out && coef_idx_out == k) && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (!(coef_valid_out && coef_idx_out == k)) begin
            fails++;
            $display("FAIL %s wait: got idx=%0d valid=%0b, required idx=%0d valid=1", name, coef_idx_out, coef_valid_out, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_valid_in = 1'b0;
        frame_mode_in = 1'b0;
        coef_ready_in = 1'b0;
        frame_in = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({coef_out, coef_idx_out, coef_mode_out, coef_last_out, coef_valid_out, buf_full, overflow_out, drop_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got d=%0d idx=%0d valid=%0b full=%0b ovf=%0b drops=%0d, required all 0",
                     coef_out, coef_idx_out, coef_valid_out, buf_full, overflow_out, drop_count);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (coef_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got valid=%0b, required 0", coef_valid_out);
        end
    endtask

    task automatic test_forward(input logic m);
        coef_ready_in = 1'b1;
        frame_in = {32'd0, 32'd40, 32'd20, 32'd60, 32'd10, 32'd50, 32'd30, 32'd70};
        frame_mode_in = m;
        frame_valid_in = 1'b1;
        for (int i = 0; i < 8; i++)
            sb.push_back({m ? 32'((10 * i * 211) % 241) : 32'(10 * i), 3'(i), m, (i == 7)});
        tick();
        frame_valid_in = 1'b0;
        tests++;
        if (coef_valid_out !== 1'b0 || buf_full !== 1'b0) begin
            fails++;
            $display("FAIL latency_e0: got valid=%0b full=%0b, required valid=0 full=0", coef_valid_out, buf_full);
        end
        tick();
        tests++;
        if (coef_valid_out !== 1'b1 || coef_idx_out !== 3'd0 || coef_mode_out !== m) begin
            fails++;
            $display("FAIL latency_e1: got valid=%0b idx=%0d mode=%0b, required valid=1 idx=0 mode=%0b",
                     coef_valid_out, coef_idx_out, coef_mode_out, m);
        end
        drain(m ? "intt" : "forward");
    endtask

    task automatic test_backpressure();
        coef_ready_in = 1'b1;
        fill();
        present(1'b1, 1'b1);
        wait_idx("backpressure", 3'd2);
        coef_ready_in = 1'b0;
        repeat (3) tick();
        tests++;
        if (coef_valid_out !== 1'b1 || coef_idx_out !== 3'd2) begin
            fails++;
            $display("FAIL backpressure_hold: got valid=%0b idx=%0d, required valid=1 idx=2", coef_valid_out, coef_idx_out);
        end
        drain("backpressure");
    endtask

    task automatic test_overflow();
        coef_ready_in = 1'b0;
        fill();
        present(1'b0, 1'b1);
        fill();
        present(1'b1, 1'b1);
        tests++;
        if (buf_full !== 1'b1) begin
            fails++;
            $display("FAIL overflow_full: got buf_full=%0b, required 1", buf_full);
        end
        fill();
        present(1'b0, 1'b0);
        exp_drops++;
        tests++;
        if (overflow_out !== 1'b1 || drop_count !== 8'(exp_drops)) begin
            fails++;
            $display("FAIL overflow_pulse: got ovf=%0b drops=%0d, required ovf=1 drops=%0d", overflow_out, drop_count, exp_drops);
        end
        tick();
        tests++;
        if (overflow_out !== 1'b0) begin
            fails++;
            $display("FAIL overflow_single: got ovf=%0b, required 0", overflow_out);
        end
        coef_ready_in = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (coef_valid_out !== 1'b1) begin
                fails++;
                $display("FAIL overflow_bubble: got valid=%0b at beat %0d, required 1", coef_valid_out, k);
            end
            tick();
        end
        drain("overflow");
    endtask

    task automatic test_saturate();
        coef_ready_in = 1'b0;
        fill();
        present(1'b1, 1'b1);
        fill();
        present(1'b0, 1'b1);
        repeat (300) present(1'b0, 1'b0);
        exp_drops = (exp_drops + 300 > 255) ? 255 : exp_drops + 300;
        tests++;
        if (drop_count !== 8'(exp_drops) || overflow_out !== 1'b1) begin
            fails++;
            $display("FAIL saturate: got drops=%0d ovf=%0b, required drops=%0d ovf=1", drop_count, overflow_out, exp_drops);
        end
        drain("saturate");
    endtask

    task automatic test_simul();
        coef_ready_in = 1'b1;
        fill();
        present(1'b0, 1'b1);
        fill();
        present(1'b1, 1'b1);
        tests++;
        if (buf_full !== 1'b1) begin
            fails++;
            $display("FAIL simul_full: got buf_full=%0b, required 1", buf_full);
        end
        repeat (6) tick();
        fill();
        present(1'b1, 1'b1);
        tests++;
        if (overflow_out !== 1'b0 || drop_count !== 8'(exp_drops) || buf_full !== 1'b1 || coef_idx_out !== 3'd7) begin
            fails++;
            $display("FAIL simul_release: got ovf=%0b drops=%0d full=%0b idx=%0d, required ovf=0 drops=%0d full=1 idx=7",
                     overflow_out, drop_count, buf_full, coef_idx_out, exp_drops);
        end
        drain("simul");
    endtask

    task automatic test_reset_mid();
        coef_ready_in = 1'b1;
        fill();
        present(1'b0, 1'b1);
        wait_idx("reset_mid", 3'd4);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({coef_out, coef_idx_out, coef_mode_out, coef_last_out, coef_valid_out, buf_full, overflow_out, drop_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got d=%0d idx=%0d valid=%0b full=%0b drops=%0d, required all 0",
                     coef_out, coef_idx_out, coef_valid_out, buf_full, drop_count);
        end
        sb.delete();
        exp_drops = 0;
        hold_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        fill();
        present(1'b1, 1'b1);
        tick();
        tests++;
        if (coef_valid_out !== 1'b1 || coef_idx_out !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_restart: got valid=%0b idx=%0d, required valid=1 idx=0", coef_valid_out, coef_idx_out);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_forward(1'b0);
        test_forward(1'b1);
        test_backpressure();
        test_overflow();
        test_saturate();
        test_simul();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
